// File: rtl/scs8hd_dlxtn_pkg.sv
// Shared types and helpers for the synchronous negative-gated latch bank.
// Holds the channel FSM states, the violation flag layout and a saturating adder.
package scs8hd_dlxtn_pkg;

  typedef enum logic [1:0] {
    CLOSED   = 2'd0,
    OPEN     = 2'd1,
    HOLD_CHK = 2'd2
  } state_e;

  localparam int V_WIDTH = 0;
  localparam int V_SETUP = 1;
  localparam int V_HOLD  = 2;
  localparam int V_NUM   = 3;

  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/scs8hd_dlxtn_chan.sv
// One negative-gated latch channel: transparent output path, capture register
// and the width/setup/hold timing checks evaluated against CLK.
module scs8hd_dlxtn_chan
  import scs8hd_dlxtn_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MIN_WIDTH = 2,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int CORRUPT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  input  logic             gaten_i,
  input  logic             chk_en_i,
  output logic [WIDTH-1:0] q_o,
  output logic [V_NUM-1:0] viol_o
);

  localparam int WCW = (MIN_WIDTH < 1) ? 1 : $clog2(MIN_WIDTH + 1);
  localparam int SCW = (SETUP_CYC < 1) ? 1 : $clog2(SETUP_CYC + 1);
  localparam int HCW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WCW-1:0]   width_q, width_d;
  logic [SCW-1:0]   stab_q, stab_d;
  logic [HCW-1:0]   hold_q, hold_d;

  assign q_o = gaten_i ? q_q : d_i;

  // NOTE: every variable gets a default first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    width_d = width_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    viol_o  = '0;
    case (state_q)
      OPEN: begin
        if (!gaten_i) begin
          q_d     = d_i;
          width_d = WCW'(sat_add(32'(width_q), 32'd1, 32'(MIN_WIDTH)));
          stab_d  = (d_i == q_q) ? SCW'(sat_add(32'(stab_q), 32'd1, 32'(SETUP_CYC))) : '0;
        end else begin
          viol_o[V_WIDTH] = chk_en_i && (32'(width_q) < 32'(MIN_WIDTH));
          viol_o[V_SETUP] = chk_en_i && (SETUP_CYC > 0) && (32'(stab_q) < 32'(SETUP_CYC));
          hold_d  = '0;
          state_d = (HOLD_CYC > 0) ? HOLD_CHK : CLOSED;
        end
      end
      HOLD_CHK: begin
        if (!gaten_i) begin
          state_d = OPEN;
          q_d     = d_i;
          width_d = WCW'(1);
          stab_d  = '0;
        end else if (d_i != q_q) begin
          viol_o[V_HOLD] = chk_en_i;
          state_d        = CLOSED;
        end else begin
          hold_d = HCW'(32'(hold_q) + 32'd1);
          if (32'(hold_q) + 32'd1 >= 32'(HOLD_CYC)) state_d = CLOSED;
        end
      end
      default: begin
        if (!gaten_i) begin
          state_d = OPEN;
          q_d     = d_i;
          width_d = WCW'(1);
          stab_d  = '0;
        end
      end
    endcase
    // A zeroed capture would re-flag the same event at hold time, so skip that check.
    if ((CORRUPT != 0) && (|viol_o)) begin
      q_d = '0;
      if (state_q == OPEN) state_d = CLOSED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLOSED;
      q_q     <= '0;
      width_q <= '0;
      stab_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      width_q <= width_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/scs8hd_dlxtn_bank.sv
// Bank of independent negative-gated latch channels with sticky per-channel
// timing-violation flags and a saturating violation-event counter.
module scs8hd_dlxtn_bank
  import scs8hd_dlxtn_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int MIN_WIDTH = 2,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int CORRUPT   = 1,
  parameter int CNT_W     = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       GATEN,
  input  logic                      CHK_EN,
  input  logic                      VIOL_CLR,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [3*CHANNELS-1:0]     VIOL,
  output logic [CNT_W-1:0]          VIOL_CNT
);

  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  logic [V_NUM*CHANNELS-1:0] pulse;
  logic [V_NUM*CHANNELS-1:0] viol_q, viol_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [31:0]               n_evt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    scs8hd_dlxtn_chan #(
      .WIDTH     (WIDTH),
      .MIN_WIDTH (MIN_WIDTH),
      .SETUP_CYC (SETUP_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .CORRUPT   (CORRUPT)
    ) u_chan (
      .clk      (CLK),
      .rst      (RESET),
      .d_i      (D[c*WIDTH +: WIDTH]),
      .gaten_i  (GATEN[c]),
      .chk_en_i (CHK_EN),
      .q_o      (Q[c*WIDTH +: WIDTH]),
      .viol_o   (pulse[V_NUM*c +: V_NUM])
    );
  end

  // A channel flagging several check types in one cycle is a single event.
  always_comb begin
    n_evt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      n_evt = n_evt + 32'(|pulse[V_NUM*c +: V_NUM]);
    end
    viol_d = (VIOL_CLR ? '0 : viol_q) | pulse;
    cnt_d  = CNT_W'(sat_add(VIOL_CLR ? 32'd0 : 32'(cnt_q), n_evt, CNT_MAX));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      viol_q <= '0;
      cnt_q  <= '0;
    end else begin
      viol_q <= viol_d;
      cnt_q  <= cnt_d;
    end
  end

  assign VIOL     = viol_q;
  assign VIOL_CNT = cnt_q;

endmodule
